// File: rtl/leaf_user_bridge.sv
// Leaf interface <-> user kernel bridge: per-channel registered FIFOs in both
// directions, an IDLE/RUN/DRAIN run controller and saturating beat counters.

module leaf_user_bridge_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             ap_clk,
    input  logic             ap_rst_n,
    input  logic             wr_en,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_fire,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data
);
    // DEPTH must be a power of two so the pointers wrap by plain overflow.
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             full;
    logic             rd_fire;

    assign full     = (count_q == (AW + 1)'(DEPTH));
    assign wr_ready = wr_en && !full;
    assign wr_fire  = wr_valid && wr_ready;
    assign rd_valid = (count_q != '0);
    assign rd_fire  = rd_valid && rd_ready;
    assign rd_data  = mem[rd_ptr_q];

    // NOTE: storage has no reset; clearing count_q empties the FIFO, which is all that matters.
    always_ff @(posedge ap_clk) begin
        if (wr_fire) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_fire, rd_fire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

module leaf_user_bridge #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_IN_PORTS  = 4,
    parameter int NUM_OUT_PORTS = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_BITS      = 16
) (
    input  logic                                    ap_clk,
    input  logic                                    ap_rst_n,
    input  logic                                    ap_start,
    input  logic                                    flush,
    output logic                                    ap_start_user,
    output logic                                    busy,
    input  logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    dout_leaf_interface2user,
    input  logic [NUM_IN_PORTS-1:0]                 vld_interface2user,
    output logic [NUM_IN_PORTS-1:0]                 ack_user2interface,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    user_in_tdata,
    output logic [NUM_IN_PORTS-1:0]                 user_in_tvalid,
    input  logic [NUM_IN_PORTS-1:0]                 user_in_tready,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   user_out_tdata,
    input  logic [NUM_OUT_PORTS-1:0]                user_out_tvalid,
    output logic [NUM_OUT_PORTS-1:0]                user_out_tready,
    output logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    output logic [NUM_IN_PORTS*CNT_BITS-1:0]        in_count,
    output logic [NUM_OUT_PORTS*CNT_BITS-1:0]       out_count
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t state_q;
    logic   start_user_q;
    logic   busy_q;
    logic   wr_en;
    logic   clear_cnt;
    logic   all_empty;

    assign wr_en         = (state_q == RUN);
    assign clear_cnt     = (state_q == IDLE) && ap_start;
    assign all_empty     = !(|user_in_tvalid) && !(|vld_user2interface);
    assign ap_start_user = start_user_q;
    assign busy          = busy_q;

    // Outputs are registered alongside the state so they change on the same edge.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= IDLE;
            start_user_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (ap_start) begin
                    state_q      <= RUN;
                    start_user_q <= 1'b1;
                    busy_q       <= 1'b1;
                end
                RUN: if (flush) begin
                    state_q      <= DRAIN;
                    start_user_q <= 1'b0;
                end
                DRAIN: if (all_empty) begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    start_user_q <= 1'b0;
                    busy_q       <= 1'b0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_in
        logic                wr_fire;
        logic [CNT_BITS-1:0] cnt_q;

        leaf_user_bridge_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
            .ap_clk   (ap_clk),
            .ap_rst_n (ap_rst_n),
            .wr_en    (wr_en),
            .wr_valid (vld_interface2user[i]),
            .wr_ready (ack_user2interface[i]),
            .wr_data  (dout_leaf_interface2user[i*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .wr_fire  (wr_fire),
            .rd_valid (user_in_tvalid[i]),
            .rd_ready (user_in_tready[i]),
            .rd_data  (user_in_tdata[i*PAYLOAD_BITS +: PAYLOAD_BITS])
        );

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n)                    cnt_q <= '0;
            else if (clear_cnt)               cnt_q <= '0;
            else if (wr_fire && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
        end

        assign in_count[i*CNT_BITS +: CNT_BITS] = cnt_q;
    end

    for (genvar j = 0; j < NUM_OUT_PORTS; j++) begin : g_out
        logic                wr_fire;
        logic [CNT_BITS-1:0] cnt_q;

        leaf_user_bridge_fifo #(.WIDTH(PAYLOAD_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
            .ap_clk   (ap_clk),
            .ap_rst_n (ap_rst_n),
            .wr_en    (wr_en),
            .wr_valid (user_out_tvalid[j]),
            .wr_ready (user_out_tready[j]),
            .wr_data  (user_out_tdata[j*PAYLOAD_BITS +: PAYLOAD_BITS]),
            .wr_fire  (wr_fire),
            .rd_valid (vld_user2interface[j]),
            .rd_ready (ack_interface2user[j]),
            .rd_data  (din_leaf_user2interface[j*PAYLOAD_BITS +: PAYLOAD_BITS])
        );

        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n)                    cnt_q <= '0;
            else if (clear_cnt)               cnt_q <= '0;
            else if (wr_fire && cnt_q != '1)  cnt_q <= cnt_q + 1'b1;
        end

        assign out_count[j*CNT_BITS +: CNT_BITS] = cnt_q;
    end
endmodule

// File: tb/tb_leaf_user_bridge.sv
// Directed bench for leaf_user_bridge: start, backpressure, full-FIFO refusal,
// flush/drain, counter saturation and asynchronous reset.

module tb_leaf_user_bridge;
    localparam int PB = 32;
    localparam int NI = 4;
    localparam int NO = 3;
    localparam int FD = 4;
    localparam int CB = 4;

    logic             ap_clk = 1'b0;
    logic             ap_rst_n = 1'b0;
    logic             ap_start = 1'b0;
    logic             flush = 1'b0;
    logic             ap_start_user;
    logic             busy;
    logic [NI*PB-1:0] dout_leaf_interface2user = '0;
    logic [NI-1:0]    vld_interface2user = '0;
    logic [NI-1:0]    ack_user2interface;
    logic [NI*PB-1:0] user_in_tdata;
    logic [NI-1:0]    user_in_tvalid;
    logic [NI-1:0]    user_in_tready = '0;
    logic [NO*PB-1:0] user_out_tdata = '0;
    logic [NO-1:0]    user_out_tvalid = '0;
    logic [NO-1:0]    user_out_tready;
    logic [NO*PB-1:0] din_leaf_user2interface;
    logic [NO-1:0]    vld_user2interface;
    logic [NO-1:0]    ack_interface2user = '0;
    logic [NI*CB-1:0] in_count;
    logic [NO*CB-1:0] out_count;

    int checks = 0;
    int errors = 0;

    leaf_user_bridge #(
        .PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO),
        .FIFO_DEPTH(FD), .CNT_BITS(CB)
    ) dut (
        .ap_clk                   (ap_clk),
        .ap_rst_n                 (ap_rst_n),
        .ap_start                 (ap_start),
        .flush                    (flush),
        .ap_start_user            (ap_start_user),
        .busy                     (busy),
        .dout_leaf_interface2user (dout_leaf_interface2user),
        .vld_interface2user       (vld_interface2user),
        .ack_user2interface       (ack_user2interface),
        .user_in_tdata            (user_in_tdata),
        .user_in_tvalid           (user_in_tvalid),
        .user_in_tready           (user_in_tready),
        .user_out_tdata           (user_out_tdata),
        .user_out_tvalid          (user_out_tvalid),
        .user_out_tready          (user_out_tready),
        .din_leaf_user2interface  (din_leaf_user2interface),
        .vld_user2interface       (vld_user2interface),
        .ack_interface2user       (ack_interface2user),
        .in_count                 (in_count),
        .out_count                (out_count)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Outputs are observed and inputs driven 1ns after each rising edge.
    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic logic [PB-1:0] in_data(int ch);
        return user_in_tdata[ch*PB +: PB];
    endfunction

    function automatic logic [PB-1:0] out_data(int ch);
        return din_leaf_user2interface[ch*PB +: PB];
    endfunction

    function automatic logic [CB-1:0] in_cnt(int ch);
        return in_count[ch*CB +: CB];
    endfunction

    function automatic logic [CB-1:0] out_cnt(int ch);
        return out_count[ch*CB +: CB];
    endfunction

    task automatic test_reset();
        #12;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (ap_start_user !== 1'b0) begin errors++; $display("FAIL rst_start_user got %b exp 0", ap_start_user); end
        checks++; if (user_in_tvalid !== '0) begin errors++; $display("FAIL rst_in_tvalid got %b exp 0", user_in_tvalid); end
        checks++; if (vld_user2interface !== '0) begin errors++; $display("FAIL rst_out_vld got %b exp 0", vld_user2interface); end
        checks++; if (ack_user2interface !== '0) begin errors++; $display("FAIL rst_in_ack got %b exp 0", ack_user2interface); end
        checks++; if (user_out_tready !== '0) begin errors++; $display("FAIL rst_out_tready got %b exp 0", user_out_tready); end
        checks++; if (in_count !== '0 || out_count !== '0) begin errors++; $display("FAIL rst_counts got %h/%h exp 0", in_count, out_count); end
        ap_rst_n = 1'b1;
        repeat (3) step();
        checks++; if (busy !== 1'b0 || ack_user2interface !== '0) begin errors++; $display("FAIL idle_hold busy %b ack %b exp 0/0", busy, ack_user2interface); end
    endtask

    task automatic test_start();
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        checks++; if (ap_start_user !== 1'b1) begin errors++; $display("FAIL start_user got %b exp 1", ap_start_user); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b exp 1", busy); end
        checks++; if (ack_user2interface !== 4'hF) begin errors++; $display("FAIL start_ack got %h exp f", ack_user2interface); end
        checks++; if (user_out_tready !== 3'h7) begin errors++; $display("FAIL start_tready got %h exp 7", user_out_tready); end
        dout_leaf_interface2user[0 +: PB] = 32'hA5A5_A5A5;
        vld_interface2user[0] = 1'b1;
        step();
        vld_interface2user[0] = 1'b0;
        checks++; if (user_in_tvalid[0] !== 1'b1 || in_data(0) !== 32'hA5A5_A5A5) begin
            errors++; $display("FAIL ch0_beat valid %b data %h exp 1 a5a5a5a5", user_in_tvalid[0], in_data(0)); end
        checks++; if (in_cnt(0) !== 4'd1) begin errors++; $display("FAIL ch0_count got %0d exp 1", in_cnt(0)); end
        user_in_tready[0] = 1'b1;
        step();
        user_in_tready[0] = 1'b0;
        checks++; if (user_in_tvalid[0] !== 1'b0) begin errors++; $display("FAIL ch0_drained valid %b exp 0", user_in_tvalid[0]); end
    endtask

    task automatic test_backpressure();
        int idx = 0;
        logic will_send;
        for (int k = 0; k < 4; k++) begin
            checks++; if (ack_user2interface[1] !== 1'b1) begin errors++; $display("FAIL bp_ack%0d got %b exp 1", k, ack_user2interface[1]); end
            dout_leaf_interface2user[1*PB +: PB] = 32'h100 + k;
            vld_interface2user[1] = 1'b1;
            step();
        end
        dout_leaf_interface2user[1*PB +: PB] = 32'h104;
        checks++; if (ack_user2interface[1] !== 1'b0) begin errors++; $display("FAIL bp_full_ack got %b exp 0", ack_user2interface[1]); end
        checks++; if (in_cnt(1) !== 4'd4) begin errors++; $display("FAIL bp_count4 got %0d exp 4", in_cnt(1)); end
        user_in_tready[1] = 1'b1;
        for (int cyc = 0; cyc < 20 && (idx < 5 || vld_interface2user[1]); cyc++) begin
            if (user_in_tvalid[1]) begin
                checks++; if (in_data(1) !== 32'h100 + idx) begin errors++; $display("FAIL bp_order%0d got %h exp %h", idx, in_data(1), 32'h100 + idx); end
                idx++;
            end
            will_send = vld_interface2user[1] & ack_user2interface[1];
            step();
            if (will_send) vld_interface2user[1] = 1'b0;
        end
        user_in_tready[1] = 1'b0;
        checks++; if (idx != 5) begin errors++; $display("FAIL bp_delivered got %0d exp 5", idx); end
        checks++; if (in_cnt(1) !== 4'd5) begin errors++; $display("FAIL bp_count5 got %0d exp 5", in_cnt(1)); end
    endtask

    task automatic test_full_rw();
        int n;
        logic [PB-1:0] exp_q [$];
        for (int k = 0; k < 4; k++) begin
            checks++; if (ack_user2interface[2] !== 1'b1) begin errors++; $display("FAIL full_ack%0d got %b exp 1", k, ack_user2interface[2]); end
            dout_leaf_interface2user[2*PB +: PB] = 32'h200 + k;
            vld_interface2user[2] = 1'b1;
            step();
        end
        checks++; if (ack_user2interface[2] !== 1'b0) begin errors++; $display("FAIL full_ack_low got %b exp 0", ack_user2interface[2]); end
        dout_leaf_interface2user[2*PB +: PB] = 32'h2FF;
        user_in_tready[2] = 1'b1;
        checks++; if (in_data(2) !== 32'h200) begin errors++; $display("FAIL full_head got %h exp 200", in_data(2)); end
        step();
        vld_interface2user[2] = 1'b0;
        checks++; if (ack_user2interface[2] !== 1'b1) begin errors++; $display("FAIL full_after_read_ack got %b exp 1", ack_user2interface[2]); end
        exp_q = '{32'h201, 32'h202, 32'h203};
        n = 0;
        while (user_in_tvalid[2] && n < 10) begin
            checks++; if (n >= 3 || in_data(2) !== exp_q[n]) begin errors++; $display("FAIL full_drain%0d got %h", n, in_data(2)); end
            n++;
            step();
        end
        checks++; if (n != 3) begin errors++; $display("FAIL full_occupancy got %0d beats exp 3", n); end
        checks++; if (in_cnt(2) !== 4'd4) begin errors++; $display("FAIL full_count got %0d exp 4", in_cnt(2)); end

        user_in_tready[2] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dout_leaf_interface2user[2*PB +: PB] = 32'h210 + k;
            vld_interface2user[2] = 1'b1;
            step();
        end
        dout_leaf_interface2user[2*PB +: PB] = 32'h212;
        user_in_tready[2] = 1'b1;
        checks++; if (in_data(2) !== 32'h210) begin errors++; $display("FAIL half_head got %h exp 210", in_data(2)); end
        step();
        vld_interface2user[2] = 1'b0;
        exp_q = '{32'h211, 32'h212};
        n = 0;
        while (user_in_tvalid[2] && n < 10) begin
            checks++; if (n >= 2 || in_data(2) !== exp_q[n]) begin errors++; $display("FAIL half_drain%0d got %h", n, in_data(2)); end
            n++;
            step();
        end
        user_in_tready[2] = 1'b0;
        checks++; if (n != 2) begin errors++; $display("FAIL half_occupancy got %0d beats exp 2", n); end
    endtask

    task automatic test_flush();
        int n;
        int cyc;
        for (int k = 0; k < 3; k++) begin
            checks++; if (user_out_tready[2] !== 1'b1) begin errors++; $display("FAIL out_tready%0d got %b exp 1", k, user_out_tready[2]); end
            user_out_tdata[2*PB +: PB] = 32'h300 + k;
            user_out_tvalid[2] = 1'b1;
            step();
        end
        user_out_tvalid[2] = 1'b0;
        checks++; if (vld_user2interface[2] !== 1'b1 || out_data(2) !== 32'h300) begin
            errors++; $display("FAIL out_head valid %b data %h exp 1 300", vld_user2interface[2], out_data(2)); end
        checks++; if (out_cnt(2) !== 4'd3) begin errors++; $display("FAIL out_count got %0d exp 3", out_cnt(2)); end
        flush = 1'b1;
        ap_start = 1'b1;
        step();
        flush = 1'b0;
        ap_start = 1'b0;
        checks++; if (user_out_tready !== '0 || ack_user2interface !== '0) begin
            errors++; $display("FAIL drain_writes tready %b ack %b exp 0/0", user_out_tready, ack_user2interface); end
        checks++; if (ap_start_user !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL drain_state start_user %b busy %b exp 0/1", ap_start_user, busy); end
        ack_interface2user[2] = 1'b1;
        n = 0;
        while (vld_user2interface[2] && n < 10) begin
            checks++; if (out_data(2) !== 32'h300 + n) begin errors++; $display("FAIL drain_beat%0d got %h exp %h", n, out_data(2), 32'h300 + n); end
            n++;
            step();
        end
        checks++; if (n != 3) begin errors++; $display("FAIL drain_count got %0d exp 3", n); end
        cyc = 0;
        while (busy && cyc < 3) begin
            step();
            cyc++;
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_idle busy %b exp 0 after %0d cycles", busy, cyc); end
        ack_interface2user = '0;
    endtask

    task automatic test_saturate();
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        checks++; if (busy !== 1'b1 || in_cnt(0) !== 4'd0 || in_cnt(1) !== 4'd0) begin
            errors++; $display("FAIL restart busy %b cnt0 %0d cnt1 %0d exp 1 0 0", busy, in_cnt(0), in_cnt(1)); end
        user_in_tready[0] = 1'b1;
        vld_interface2user[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 10) begin
                checks++; if (in_cnt(0) !== 4'd10) begin errors++; $display("FAIL sat_mid got %0d exp 10", in_cnt(0)); end
            end
            checks++; if (ack_user2interface[0] !== 1'b1) begin errors++; $display("FAIL sat_ack%0d got %b exp 1", k, ack_user2interface[0]); end
            dout_leaf_interface2user[0 +: PB] = k;
            step();
        end
        vld_interface2user[0] = 1'b0;
        checks++; if (in_cnt(0) !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d exp 15", in_cnt(0)); end
        step();
        user_in_tready[0] = 1'b0;
    endtask

    task automatic test_async_reset();
        dout_leaf_interface2user[3*PB +: PB] = 32'h400;
        vld_interface2user[3] = 1'b1;
        user_out_tdata[0 +: PB] = 32'h500;
        user_out_tvalid[0] = 1'b1;
        step();
        step();
        vld_interface2user[3] = 1'b0;
        user_out_tvalid[0] = 1'b0;
        checks++; if (user_in_tvalid[3] !== 1'b1 || vld_user2interface[0] !== 1'b1) begin
            errors++; $display("FAIL ar_loaded in %b out %b exp 1/1", user_in_tvalid[3], vld_user2interface[0]); end
        #2 ap_rst_n = 1'b0;
        #1;
        checks++; if (user_in_tvalid !== '0 || vld_user2interface !== '0) begin
            errors++; $display("FAIL ar_valid in %b out %b exp 0/0", user_in_tvalid, vld_user2interface); end
        checks++; if (busy !== 1'b0 || ap_start_user !== 1'b0) begin
            errors++; $display("FAIL ar_state busy %b start_user %b exp 0/0", busy, ap_start_user); end
        #2 ap_rst_n = 1'b1;
        user_in_tready = '1;
        ack_interface2user = '1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (user_in_tvalid !== '0 || vld_user2interface !== '0) begin
                errors++; $display("FAIL ar_stale%0d in %b out %b exp 0/0", k, user_in_tvalid, vld_user2interface); end
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_backpressure();
        test_full_rw();
        test_flush();
        test_saturate();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/leaf_user_bridge.md
LEAF_USER_BRIDGE -- requirements
Module: leaf_user_bridge

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 32: data width of every channel.
REQ-002 SHALL have parameter NUM_IN_PORTS, default 4: interface-to-user channels.
REQ-003 SHALL have parameter NUM_OUT_PORTS, default 3: user-to-interface channels.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: per-channel buffer entries; must be a power of two and at least 2.
REQ-005 SHALL have parameter CNT_BITS, default 16: width of each per-channel beat counter.
REQ-006 SHALL have port ap_clk, input, 1: the only clock; all state changes on its rising edge.
REQ-007 SHALL have port ap_rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port ap_start, input, 1: run request from the leaf interface.
REQ-009 SHALL have port flush, input, 1: drain request.
REQ-010 SHALL have port ap_start_user, output, 1: kernel start level.
REQ-011 SHALL have port busy, output, 1: high when state is not IDLE.
REQ-012 SHALL have ports dout_leaf_interface2user (input, NUM_IN_PORTS*PAYLOAD_BITS), vld_interface2user (input, NUM_IN_PORTS) and ack_user2interface (output, NUM_IN_PORTS): interface-side inbound channels, channel i in slice i.
REQ-013 SHALL have ports user_in_tdata (output, NUM_IN_PORTS*PAYLOAD_BITS), user_in_tvalid (output, NUM_IN_PORTS) and user_in_tready (input, NUM_IN_PORTS): kernel-side inbound channels.
REQ-014 SHALL have ports user_out_tdata (input, NUM_OUT_PORTS*PAYLOAD_BITS), user_out_tvalid (input, NUM_OUT_PORTS) and user_out_tready (output, NUM_OUT_PORTS): kernel-side outbound channels.
REQ-015 SHALL have ports din_leaf_user2interface (output, NUM_OUT_PORTS*PAYLOAD_BITS), vld_user2interface (output, NUM_OUT_PORTS) and ack_interface2user (input, NUM_OUT_PORTS): interface-side outbound channels.
REQ-016 SHALL have ports in_count (output, NUM_IN_PORTS*CNT_BITS) and out_count (output, NUM_OUT_PORTS*CNT_BITS): per-channel accepted-beat counters.

Function
REQ-017 Each channel SHALL hold an independent FIFO_DEPTH-entry FIFO; a beat transfers on a side when valid and ready/ack are both high in the same cycle.
REQ-018 FIFO outputs SHALL be registered (no fall-through): a beat written in cycle N is first visible downstream in cycle N+1.
REQ-019 A write port's ready SHALL be (not full) AND write-enabled; a full FIFO SHALL NOT accept a write even while it is being read in the same cycle.
REQ-020 Downstream valid SHALL equal "not empty"; data SHALL be held stable while valid is high and ready is low.
REQ-021 A simultaneous read and write on a non-empty, non-full FIFO SHALL leave occupancy unchanged; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 The FSM SHALL have three states: IDLE, RUN and DRAIN.
REQ-023 IDLE->RUN SHALL occur when ap_start is high; on that transition every in_count and out_count SHALL clear to 0.
REQ-024 RUN->DRAIN SHALL occur when flush is high; flush has priority over ap_start.
REQ-025 DRAIN->IDLE SHALL occur in the first cycle in which all FIFOs are empty.
REQ-026 ap_start_user SHALL be high only in RUN.
REQ-027 Writes SHALL be enabled in RUN only; in IDLE and DRAIN, ack_user2interface and user_out_tready SHALL be 0.
REQ-028 Reads (downstream valid) SHALL be enabled in every state.
REQ-029 A counter SHALL increment by 1 per accepted write beat on its channel and saturate at 2^CNT_BITS-1.

Reset
REQ-030 While ap_rst_n is low the block SHALL be in IDLE with all FIFOs empty, all counters 0, and all valid, ready, ap_start_user and busy outputs 0.
REQ-031 Reset assertion mid-transfer SHALL discard buffered data immediately, without waiting for a clock edge.
REQ-032 After ap_rst_n deasserts, the block SHALL stay in IDLE until ap_start is sampled high.

Verification
REQ-033 Reset then ap_start=1: next cycle ap_start_user=1, busy=1, all ack_user2interface=1; drive 0xA5A5A5A5 on inbound ch0 in cycle N -> user_in_tvalid[0]=1 with that data in cycle N+1.
REQ-034 Hold user_in_tready[1]=0 and push 5 beats on inbound ch1 with FIFO_DEPTH=4 -> ack_user2interface[1] drops after the 4th beat; release tready -> beats delivered in order; in_count[1]=4 then 5.
REQ-035 Full FIFO with read and write offered in the same cycle -> write refused, occupancy goes 4->3; with 2 entries, simultaneous read+write -> occupancy stays 2.
REQ-036 In RUN with 3 beats buffered on outbound ch2, assert flush -> user_out_tready=0 and ap_start_user=0; with ack_interface2user=1 all 3 beats emerge, then IDLE and busy=0 in the following cycle.
REQ-037 With CNT_BITS=4, send 20 beats on inbound ch0 -> in_count[0] holds at 15.
REQ-038 Drop ap_rst_n asynchronously with FIFOs non-empty -> all valid outputs read 0 before the next clock edge; after reset release no stale beat appears.
